// File: rtl/ropuf_key_collector_pkg.sv
// Shared build constants for the RO-PUF key collector and the PUF it drives.
// Also holds the counter-width helper used by the collector and its voter.
package ropuf_key_collector_pkg;

    localparam int DEF_NBITS_ROPUF = 8;
    localparam int DEF_N_KEY       = 16;
    localparam int DEF_N_VOTE      = 3;
    localparam int DEF_N_SETTLE    = 2;

    localparam int STATE_W = 3;

    // Bits needed to hold values 0..n inclusive, never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ropuf_key_collector_if.sv
// Bus between the key collector, its requester/consumer and the RO PUF.
// start/seed: request accepted only while the collector is idle; key/unstable_count are held while key_valid=1, and key_ack is acted on only while key_valid=1.
interface ropuf_key_collector_if
    import ropuf_key_collector_pkg::*;
#(
    parameter int NBITS_ROPUF = DEF_NBITS_ROPUF,
    parameter int N_KEY       = DEF_N_KEY
);
    localparam int UC_W = cnt_w(N_KEY);

    logic                   start;
    logic [NBITS_ROPUF-1:0] seed;
    logic                   response;
    logic                   puf_enable;
    logic [NBITS_ROPUF-1:0] challenge;
    logic                   busy;
    logic                   key_valid;
    logic                   key_ack;
    logic [N_KEY-1:0]       key;
    logic [UC_W-1:0]        unstable_count;

    modport master (
        input  start, seed, response, key_ack,
        output puf_enable, challenge, busy, key_valid, key, unstable_count
    );

    modport slave (
        output start, seed, response, key_ack,
        input  puf_enable, challenge, busy, key_valid, key, unstable_count
    );

endinterface

// File: rtl/ropuf_key_collector_majority_voter.sv
// Accumulates PUF response votes for one key bit and produces the
// majority bit plus a flag when the votes were not unanimous.
module majority_voter
    import ropuf_key_collector_pkg::*;
#(
    parameter int N_VOTE = DEF_N_VOTE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic sample_i,
    input  logic response_i,
    output logic last_vote_o,
    output logic bit_o,
    output logic unstable_o
);

    localparam int VW = cnt_w(N_VOTE);

    logic [VW-1:0] ones_q, ones_d;
    logic [VW-1:0] votes_q, votes_d;

    always_comb begin
        ones_d  = ones_q;
        votes_d = votes_q;
        if (clear_i) begin
            ones_d  = '0;
            votes_d = '0;
        end else if (sample_i) begin
            ones_d  = ones_q + VW'(response_i);
            votes_d = votes_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ones_q  <= '0;
            votes_q <= '0;
        end else begin
            ones_q  <= ones_d;
            votes_q <= votes_d;
        end
    end

    // The sample being taken now is the last one when N_VOTE-1 are already in.
    assign last_vote_o = (votes_q == VW'(N_VOTE - 1));
    assign bit_o       = (ones_q > VW'(N_VOTE / 2));
    assign unstable_o  = (ones_q != '0) && (ones_q != VW'(N_VOTE));

endmodule

// File: rtl/ropuf_key_collector.sv
// Drives an RO PUF through a challenge sequence, majority-votes each response
// bit and assembles the key (first bit in the MSB) with an instability count.
module ropuf_key_collector
    import ropuf_key_collector_pkg::*;
#(
    parameter int NBITS_ROPUF = DEF_NBITS_ROPUF,
    parameter int N_KEY       = DEF_N_KEY,
    parameter int N_VOTE      = DEF_N_VOTE,
    parameter int N_SETTLE    = DEF_N_SETTLE
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ropuf_key_collector_if.master    bus,
    output logic [STATE_W-1:0]       state_o
);

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_APPLY  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SAMPLE = 3'd2;
    localparam logic [STATE_W-1:0] ST_DECIDE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

    localparam int KW = cnt_w(N_KEY);
    localparam int SW = cnt_w(N_SETTLE);

    logic [STATE_W-1:0]     state_q, state_d;
    logic                   launch_q, launch_d;
    logic [NBITS_ROPUF-1:0] chal_q, chal_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [KW-1:0]          bit_q, bit_d;
    logic [N_KEY-1:0]       key_q, key_d;
    logic [KW-1:0]          uc_q, uc_d;

    logic voter_clear;
    logic voter_sample;
    logic last_vote;
    logic vote_bit;
    logic vote_unstable;

    majority_voter #(
        .N_VOTE (N_VOTE)
    ) u_voter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (voter_clear),
        .sample_i    (voter_sample),
        .response_i  (bus.response),
        .last_vote_o (last_vote),
        .bit_o       (vote_bit),
        .unstable_o  (vote_unstable)
    );

    always_comb begin
        state_d      = state_q;
        launch_d     = launch_q;
        chal_d       = chal_q;
        settle_d     = settle_q;
        bit_d        = bit_q;
        key_d        = key_q;
        uc_d         = uc_q;
        voter_clear  = 1'b0;
        voter_sample = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Capture cycle first, so the seed is on the challenge bus one
                // cycle before the PUF is enabled.
                if (launch_q) begin
                    launch_d = 1'b0;
                    state_d  = ST_APPLY;
                end else if (bus.start) begin
                    launch_d    = 1'b1;
                    chal_d      = bus.seed;
                    settle_d    = '0;
                    bit_d       = '0;
                    key_d       = '0;
                    uc_d        = '0;
                    voter_clear = 1'b1;
                end
            end
            ST_APPLY: begin
                if (settle_q == SW'(N_SETTLE - 1)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                voter_sample = 1'b1;
                state_d      = last_vote ? ST_DECIDE : ST_APPLY;
            end
            ST_DECIDE: begin
                key_d       = (key_q << 1) | N_KEY'(vote_bit);
                uc_d        = vote_unstable ? uc_q + 1'b1 : uc_q;
                chal_d      = chal_q + 1'b1;
                bit_d       = bit_q + 1'b1;
                voter_clear = 1'b1;
                state_d     = (bit_q == KW'(N_KEY - 1)) ? ST_DONE : ST_APPLY;
            end
            ST_DONE: begin
                if (bus.key_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                launch_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            chal_q   <= '0;
            settle_q <= '0;
            bit_q    <= '0;
            key_q    <= '0;
            uc_q     <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            chal_q   <= chal_d;
            settle_q <= settle_d;
            bit_q    <= bit_d;
            key_q    <= key_d;
            uc_q     <= uc_d;
        end
    end

    assign bus.puf_enable     = (state_q == ST_APPLY) || (state_q == ST_SAMPLE) ||
                                (state_q == ST_DECIDE);
    assign bus.busy           = bus.puf_enable;
    assign bus.key_valid      = (state_q == ST_DONE);
    assign bus.challenge      = chal_q;
    assign bus.key            = key_q;
    assign bus.unstable_count = uc_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_ropuf_key_collector.sv
// Directed bench for ropuf_key_collector with default parameters: a vector
// table of complete runs plus hand-written reset/ack/start corner sequences.
module tb_ropuf_key_collector;
  import ropuf_key_collector_pkg::*;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam int LATENCY = 161;

  localparam int M_ZERO = 0, M_ONES = 1, M_ALT = 2, M_PARITY = 3;

  typedef struct {
    int         mode;
    logic [7:0] seed;
    logic [15:0] key;
    logic [4:0] uc;
    logic [7:0] chal_done;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ropuf_key_collector_if bus ();
  logic [2:0] state;

  ropuf_key_collector dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int mode = M_ONES;
  logic [7:0] cur_seed = 8'h00;
  int vidx = 0;
  int bidx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PUF model: drives the response for the sample cycle, noise elsewhere
  always @(negedge clk) begin
    if (state == S_SAMPLE) begin
      case (mode)
        M_ZERO:  bus.response = 1'b0;
        M_ONES:  bus.response = 1'b1;
        M_ALT:   bus.response = (vidx != 1);
        default: bus.response = bus.challenge[0];
      endcase
      vidx++;
    end else begin
      bus.response = 1'($urandom_range(0, 1));
      if (state != S_APPLY) vidx = 0;
    end
    if (state == S_DECIDE) begin
      chk("challenge_seq", 32'(bus.challenge), 32'(8'(cur_seed + 8'(bidx))));
      chk("pen_active", 32'(bus.puf_enable), 32'd1);
      bidx++;
    end else if (state == S_IDLE) begin
      bidx = 0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] seed);
    cur_seed  = seed;
    bus.seed  = seed;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.seed  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (bus.key_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("key_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_key();
    bus.key_ack = 1'b1;
    tick();
    bus.key_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    chk({tag, "_pen"}, 32'(bus.puf_enable), 32'd0);
    chk({tag, "_chal"}, 32'(bus.challenge), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_kv"}, 32'(bus.key_valid), 32'd0);
    chk({tag, "_key"}, 32'(bus.key), 32'd0);
    chk({tag, "_uc"}, 32'(bus.unstable_count), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.seed = 8'h00;
    bus.key_ack = 1'b0;

    vecs[0] = '{M_ONES,   8'hA5, 16'hFFFF, 5'd0,  8'hB5};
    vecs[1] = '{M_ZERO,   8'h7F, 16'h0000, 5'd0,  8'h8F};
    vecs[2] = '{M_ALT,    8'h3C, 16'hFFFF, 5'd16, 8'h4C};
    vecs[3] = '{M_PARITY, 8'hF8, 16'h5555, 5'd0,  8'h08};
    vecs[4] = '{M_PARITY, 8'h00, 16'h5555, 5'd0,  8'h10};
    vecs[5] = '{M_PARITY, 8'h01, 16'hAAAA, 5'd0,  8'h11};

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // table of complete runs
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      start_run(vecs[i].seed);
      wait_valid(lat);
      chk("latency", 32'(lat), 32'(LATENCY));
      chk("key", 32'(bus.key), 32'(vecs[i].key));
      chk("unstable", 32'(bus.unstable_count), 32'(vecs[i].uc));
      chk("chal_done", 32'(bus.challenge), 32'(vecs[i].chal_done));
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_pen", 32'(bus.puf_enable), 32'd0);
      tick();
      tick();
      chk("done_hold_kv", 32'(bus.key_valid), 32'd1);
      chk("done_hold_key", 32'(bus.key), 32'(vecs[i].key));
      chk("done_hold_chal", 32'(bus.challenge), 32'(vecs[i].chal_done));
      ack_key();
      chk("ack_idle", 32'(state), 32'(S_IDLE));
      chk("ack_kv", 32'(bus.key_valid), 32'd0);
      tick();
      chk("idle_key_kept", 32'(bus.key), 32'(vecs[i].key));
      chk("idle_uc_kept", 32'(bus.unstable_count), 32'(vecs[i].uc));
    end

    // reset at cycle 50 of a run, then a full fresh run
    mode = M_ONES;
    start_run(8'hA5);
    repeat (49) tick();
    chk("pre_reset_key", 32'(bus.key), 32'h000F);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrun_reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(state), 32'(S_IDLE));
    start_run(8'hA5);
    wait_valid(lat);
    chk("rerun_latency", 32'(lat), 32'(LATENCY));
    chk("rerun_key", 32'(bus.key), 32'hFFFF);
    ack_key();

    // key_ack held through the run, start pulsed mid-run
    mode = M_ONES;
    start_run(8'h11);
    lat = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 20) bus.key_ack = 1'b1;
      if (n == 30) begin
        bus.start = 1'b1;
        bus.seed = 8'h77;
      end
      if (n == 31) bus.start = 1'b0;
      if (bus.key_valid) begin
        lat = n;
        break;
      end
    end
    chk("ackheld_latency", 32'(lat), 32'(LATENCY));
    chk("ackheld_key", 32'(bus.key), 32'hFFFF);
    chk("ackheld_chal", 32'(bus.challenge), 32'h21);
    tick();
    chk("ackheld_one_cycle_kv", 32'(bus.key_valid), 32'd0);
    chk("ackheld_idle", 32'(state), 32'(S_IDLE));
    bus.key_ack = 1'b0;
    tick();
    chk("ackheld_stay_idle", 32'(state), 32'(S_IDLE));

    // start alone in DONE is ignored; start with key_ack in DONE only acks
    mode = M_ONES;
    start_run(8'h20);
    wait_valid(lat);
    bus.start = 1'b1;
    bus.seed = 8'h99;
    tick();
    bus.start = 1'b0;
    chk("done_start_ignored", 32'(state), 32'(S_DONE));
    chk("done_start_chal", 32'(bus.challenge), 32'h30);
    bus.start = 1'b1;
    bus.key_ack = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.key_ack = 1'b0;
    chk("both_high_idle", 32'(state), 32'(S_IDLE));
    tick();
    tick();
    chk("both_high_no_run", 32'(bus.busy), 32'd0);
    chk("both_high_chal", 32'(bus.challenge), 32'h30);
    chk("both_high_key", 32'(bus.key), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
